// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Clears the instruction memory, loads a length-prefixed program
//            from a byte stream, then hands fetch over to the core. Defining
//            IMEM_LOAD_CHECKSUM_EN adds a trailing 32-bit payload checksum.
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          SYS_clk,
    input  logic          SYS_reset,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    input  logic [31:0]   fetch_PC,
    output logic [AW-1:0] mem_raddr,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic          core_stall,
    output logic          load_done,
    output logic          load_error,
    output logic [AW:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
`ifdef IMEM_LOAD_CHECKSUM_EN
        S_CSUM  = 3'd3,
`endif
        S_RUN   = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);
    localparam logic [31:0]   c_depth     = 32'(DEPTH);
    localparam logic [AW:0]   c_one_cnt   = (AW+1)'(1);

    state_t        r_state,      w_state_n;
    logic          r_rx_ready,   w_rx_ready_n;
    logic          r_mem_we,     w_mem_we_n;
    logic [AW-1:0] r_mem_waddr,  w_mem_waddr_n;
    logic [31:0]   r_mem_wdata,  w_mem_wdata_n;
    logic          r_core_stall, w_core_stall_n;
    logic          r_load_done,  w_load_done_n;
    logic          r_load_error, w_load_error_n;
    logic [AW:0]   r_words,      w_words_n;
    logic [AW:0]   r_n,          w_n_n;
    logic [31:0]   r_shift,      w_shift_n;
    logic [1:0]    r_byte_cnt,   w_byte_cnt_n;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0]   r_sum,        w_sum_n;
`endif

    logic          w_hs;
    logic          w_word_done;
    logic [31:0]   w_word;
    logic          w_unused;

    // Bytes enter at the top so the first byte ends up in bits [7:0].
    assign w_hs        = rx_valid & r_rx_ready;
    assign w_word      = {rx_data, r_shift[31:8]};
    assign w_word_done = w_hs && (r_byte_cnt == 2'd3);
    assign w_unused    = ^{fetch_PC[31:AW+2], fetch_PC[1:0], r_shift[7:0]};

    assign rx_ready     = r_rx_ready;
    assign mem_we       = r_mem_we;
    assign mem_waddr    = r_mem_waddr;
    assign mem_wdata    = r_mem_wdata;
    assign core_stall   = r_core_stall;
    assign load_done    = r_load_done;
    assign load_error   = r_load_error;
    assign words_loaded = r_words;
    assign mem_raddr    = (r_state == S_RUN) ? fetch_PC[AW+1:2] : '0;

    always_comb begin
        w_state_n     = r_state;
        w_mem_we_n    = 1'b0;
        w_mem_waddr_n = r_mem_waddr;
        w_mem_wdata_n = r_mem_wdata;
        w_words_n     = r_words;
        w_n_n         = r_n;
        w_shift_n     = r_shift;
        w_byte_cnt_n  = r_byte_cnt;
`ifdef IMEM_LOAD_CHECKSUM_EN
        w_sum_n       = r_sum;
`endif
        if (w_hs) begin
            w_shift_n    = w_word;
            w_byte_cnt_n = r_byte_cnt + 2'd1;
        end

        case (r_state)
            S_CLEAR: begin
                if (r_mem_we && (r_mem_waddr == c_last_addr)) begin
                    w_state_n = S_HDR;
                end else begin
                    w_mem_we_n    = 1'b1;
                    w_mem_waddr_n = r_mem_we ? (r_mem_waddr + AW'(1)) : '0;
                    w_mem_wdata_n = '0;
                end
            end
            S_HDR: begin
                if (w_word_done) begin
                    if (w_word == 32'd0) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                        w_state_n = S_CSUM;
`else
                        w_state_n = S_RUN;
`endif
                    end else if (w_word > c_depth) begin
                        w_state_n = S_ERROR;
                    end else begin
                        w_state_n = S_DATA;
                        w_n_n     = w_word[AW:0];
                    end
                end
            end
            S_DATA: begin
`ifndef IMEM_LOAD_CHECKSUM_EN
                // Leave only once the final word's write cycle has been seen.
                if (r_mem_we && (r_words == r_n)) begin
                    w_state_n = S_RUN;
                end else
`endif
                if (w_word_done) begin
                    w_mem_we_n    = 1'b1;
                    w_mem_waddr_n = r_words[AW-1:0];
                    w_mem_wdata_n = w_word;
                    w_words_n     = r_words + c_one_cnt;
`ifdef IMEM_LOAD_CHECKSUM_EN
                    w_sum_n       = r_sum + w_word;
                    if (w_words_n == r_n) begin
                        w_state_n = S_CSUM;
                    end
`endif
                end
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            S_CSUM: begin
                if (w_word_done) begin
                    w_state_n = (w_word == r_sum) ? S_RUN : S_ERROR;
                end
            end
`endif
            S_RUN:   w_state_n = S_RUN;
            S_ERROR: w_state_n = S_ERROR;
            default: w_state_n = S_ERROR;
        endcase

        w_rx_ready_n = (w_state_n == S_HDR) || (w_state_n == S_DATA);
`ifdef IMEM_LOAD_CHECKSUM_EN
        if (w_state_n == S_CSUM) begin
            w_rx_ready_n = 1'b1;
        end
`endif
        w_core_stall_n = (w_state_n != S_RUN);
        w_load_done_n  = (w_state_n == S_RUN);
        w_load_error_n = (w_state_n == S_ERROR);
    end

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            r_state      <= S_CLEAR;
            r_rx_ready   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_waddr  <= '0;
            r_mem_wdata  <= '0;
            r_core_stall <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            r_words      <= '0;
            r_n          <= '0;
            r_shift      <= '0;
            r_byte_cnt   <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            r_sum        <= '0;
`endif
        end else begin
            r_state      <= w_state_n;
            r_rx_ready   <= w_rx_ready_n;
            r_mem_we     <= w_mem_we_n;
            r_mem_waddr  <= w_mem_waddr_n;
            r_mem_wdata  <= w_mem_wdata_n;
            r_core_stall <= w_core_stall_n;
            r_load_done  <= w_load_done_n;
            r_load_error <= w_load_error_n;
            r_words      <= w_words_n;
            r_n          <= w_n_n;
            r_shift      <= w_shift_n;
            r_byte_cnt   <= w_byte_cnt_n;
`ifdef IMEM_LOAD_CHECKSUM_EN
            r_sum        <= w_sum_n;
`endif
        end
    end

endmodule
`default_nettype wire
